// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: owns the divide
// ratio, starts/stops the divided clock and applies new ratios only on period boundaries.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] shadow;
  logic             pend;

  logic             xfer;
  logic             legal;
  logic             boundary;
  logic             at_high;
  logic [CNT_W-1:0] last;

  always_comb begin
    cfg_ready = (state == IDLE) || (state == RUN);
    xfer      = cfg_valid && cfg_ready;
    legal     = cfg_div >= CNT_W'(2);
    last      = div_active - CNT_W'(1);
    boundary  = (count == last);
    at_high   = (count >= (div_active >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      shadow     <= '0;
      pend       <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      div_active <= CNT_W'(DEFAULT_DIV);
    end else begin
      cfg_err <= xfer && !legal;

      // Period generation runs in every non-IDLE state; STOP overrides it at its boundary.
      if (state != IDLE) begin
        clk_out <= at_high;
        tick    <= boundary;
        count   <= boundary ? '0 : count + CNT_W'(1);
      end else begin
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (xfer && legal) begin
            div_active <= cfg_div;
          end
          if (en) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (xfer && legal) begin
            shadow <= cfg_div;
            pend   <= 1'b1;
            state  <= en ? PEND : STOP;
          end else if (!en) begin
            state <= STOP;
          end
        end

        PEND: begin
          if (boundary) begin
            div_active <= shadow;
            pend       <= 1'b0;
            state      <= en ? RUN : STOP;
          end else if (!en) begin
            state <= STOP;
          end
        end

        STOP: begin
          if (boundary) begin
            if (pend) begin
              div_active <= shadow;
            end
            pend    <= 1'b0;
            clk_out <= 1'b0;
            count   <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start-up, ratio changes, illegal ratios,
// stopping with a pending ratio and synchronous reset.
module tb_clk_div_ctrl;
  localparam int unsigned CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] div_active;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(5)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .div_active(div_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic phase(input string tag, input logic ec, input logic et);
    step();
    check({tag, ".clk"}, {31'd0, clk_out}, {31'd0, ec});
    check({tag, ".tick"}, {31'd0, tick}, {31'd0, et});
  endtask

  // One full period of ratio n: low for n/2 cycles, then high, tick on the last.
  task automatic run_period(input string tag, input int n);
    for (int p = 0; p < n; p++) phase(tag, p >= n / 2, p == n - 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step(); step();
    check("rst.clk", {31'd0, clk_out}, 0);
    check("rst.tick", {31'd0, tick}, 0);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.err", {31'd0, cfg_err}, 0);
    check("rst.rdy", {31'd0, cfg_ready}, 1);
    check("rst.div", {24'd0, div_active}, 5);

    // Start with default ratio 5
    rst_n = 1'b1; en = 1'b1;
    step();
    check("start.busy", {31'd0, busy}, 1);
    check("start.clk", {31'd0, clk_out}, 0);
    run_period("n5a", 5);
    run_period("n5b", 5);

    // Mid-period change to 4 at count=1
    phase("chg.p0", 1'b0, 1'b0);
    check("chg.rdy0", {31'd0, cfg_ready}, 1);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    phase("chg.p1", 1'b0, 1'b0);
    cfg_valid = 1'b0;
    check("chg.rdy1", {31'd0, cfg_ready}, 0);
    check("chg.div1", {24'd0, div_active}, 5);
    phase("chg.p2", 1'b1, 1'b0);
    check("chg.rdy2", {31'd0, cfg_ready}, 0);
    phase("chg.p3", 1'b1, 1'b0);
    check("chg.rdy3", {31'd0, cfg_ready}, 0);
    phase("chg.p4", 1'b1, 1'b1);
    check("chg.div4", {24'd0, div_active}, 4);
    check("chg.rdy4", {31'd0, cfg_ready}, 1);
    run_period("n4a", 4);
    run_period("n4b", 4);

    // Transfer 3 exactly on the boundary edge
    phase("bnd.p0", 1'b0, 1'b0);
    phase("bnd.p1", 1'b0, 1'b0);
    phase("bnd.p2", 1'b1, 1'b0);
    cfg_valid = 1'b1; cfg_div = 8'd3;
    phase("bnd.p3", 1'b1, 1'b1);
    cfg_valid = 1'b0;
    check("bnd.div", {24'd0, div_active}, 4);
    check("bnd.rdy", {31'd0, cfg_ready}, 0);
    run_period("bnd.old", 4);
    check("bnd.div3", {24'd0, div_active}, 3);
    check("bnd.rdy3", {31'd0, cfg_ready}, 1);
    run_period("n3a", 3);

    // Illegal ratios 1 and 0
    cfg_valid = 1'b1; cfg_div = 8'd1;
    phase("ill1.p0", 1'b0, 1'b0);
    cfg_valid = 1'b0;
    check("ill1.err", {31'd0, cfg_err}, 1);
    check("ill1.rdy", {31'd0, cfg_ready}, 1);
    phase("ill1.p1", 1'b1, 1'b0);
    check("ill1.err2", {31'd0, cfg_err}, 0);
    phase("ill1.p2", 1'b1, 1'b1);
    cfg_valid = 1'b1; cfg_div = 8'd0;
    phase("ill0.p0", 1'b0, 1'b0);
    cfg_valid = 1'b0;
    check("ill0.err", {31'd0, cfg_err}, 1);
    phase("ill0.p1", 1'b1, 1'b0);
    check("ill0.err2", {31'd0, cfg_err}, 0);
    phase("ill0.p2", 1'b1, 1'b1);
    check("ill.div", {24'd0, div_active}, 3);
    run_period("n3b", 3);

    // Move to ratio 6
    cfg_valid = 1'b1; cfg_div = 8'd6;
    phase("to6.p0", 1'b0, 1'b0);
    cfg_valid = 1'b0;
    phase("to6.p1", 1'b1, 1'b0);
    phase("to6.p2", 1'b1, 1'b1);
    check("to6.div", {24'd0, div_active}, 6);

    // Stop with pending ratio 8; en re-raised during STOP
    phase("stp.p0", 1'b0, 1'b0);
    phase("stp.p1", 1'b0, 1'b0);
    cfg_valid = 1'b1; cfg_div = 8'd8;
    phase("stp.p2", 1'b0, 1'b0);
    cfg_valid = 1'b0; en = 1'b0;
    phase("stp.p3", 1'b1, 1'b0);
    check("stp.rdy", {31'd0, cfg_ready}, 0);
    check("stp.busy", {31'd0, busy}, 1);
    en = 1'b1;
    phase("stp.p4", 1'b1, 1'b0);
    check("stp.div4", {24'd0, div_active}, 6);
    phase("stp.p5", 1'b0, 1'b1);
    check("stp.div", {24'd0, div_active}, 8);
    check("stp.idle", {31'd0, busy}, 0);
    check("stp.rdy2", {31'd0, cfg_ready}, 1);
    step();
    check("re.busy", {31'd0, busy}, 1);
    check("re.clk", {31'd0, clk_out}, 0);
    run_period("n8a", 8);
    run_period("n8b", 8);

    // Reset while in PEND mid-period; async assertion has no effect before the edge
    phase("rp.p0", 1'b0, 1'b0);
    phase("rp.p1", 1'b0, 1'b0);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    phase("rp.p2", 1'b0, 1'b0);
    cfg_valid = 1'b0;
    phase("rp.p3", 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    check("rp.async.busy", {31'd0, busy}, 1);
    check("rp.async.rdy", {31'd0, cfg_ready}, 0);
    check("rp.async.div", {24'd0, div_active}, 8);
    step();
    rst_n = 1'b1;
    check("rp.clk", {31'd0, clk_out}, 0);
    check("rp.tick", {31'd0, tick}, 0);
    check("rp.busy", {31'd0, busy}, 0);
    check("rp.rdy", {31'd0, cfg_ready}, 1);
    check("rp.div", {24'd0, div_active}, 5);
    step();
    check("rp.start", {31'd0, busy}, 1);
    run_period("rp.n5", 5);
    en = 1'b0;
    phase("rp.s0", 1'b0, 1'b0);
    phase("rp.s1", 1'b0, 1'b0);
    phase("rp.s2", 1'b1, 1'b0);
    phase("rp.s3", 1'b1, 1'b0);
    phase("rp.s4", 1'b0, 1'b1);
    check("rp.pend", {24'd0, div_active}, 5);
    check("rp.idle", {31'd0, busy}, 0);
    phase("rp.i0", 1'b0, 1'b0);
    check("rp.idle2", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
